uart_mmio: RTL
==============

# uart_mmio

Memory-mapped serial port for the 16-bit naive CPU system. Sits directly behind the address-decoding stage: the decoder routes CPU accesses in the I/O window to this block instead of RAM/ROM, and the returned read word is muxed back onto the CPU data path. Provides an 8N1 UART transmitter, an oversampling-free centre-sampling receiver, and a status register for CPU polling.

## Interface
- CLKS_PER_BIT, default 434, clock cycles per serial bit (50 MHz / 115200); legal range 4..65535
- RX_DEPTH, default 4, receive FIFO depth when UART_RX_FIFO_EN is defined; power of two, 2..16
- clk  in  1  system clock, rising-edge
- rst  in  1  synchronous, active-high reset
- sel  in  1  access targets this block this cycle
- addr  in  1  0 = DATA register, 1 = STATUS register
- we  in  1  write strobe, qualified by sel
- re  in  1  read strobe, qualified by sel; we and re never both high
- wdata  in  16  write data; only [7:0] used
- rdata  out  16  read data, registered
- txd  out  1  serial output, idle high
- rxd  in  1  serial input, asynchronous to clk

## Operation
- STATUS word: bit0 tx_ready (TX shifter idle), bit1 rx_avail (at least one byte held), bit2 overrun (sticky), bit3 frame_err (sticky), bits 15:4 zero.
- DATA write (sel & we & addr=0): if tx_ready, wdata[7:0] loads the TX shifter; otherwise write silently dropped. Writes to STATUS ignored.
- DATA read: rdata = {8'h00, oldest RX byte}; byte is popped. Read with nothing held returns 16'h0000, no state change.
- STATUS read: returns current status; bits 2 and 3 cleared after the read. If a new error sets in the same cycle, the set wins.
- TX FSM: IDLE -> START (txd=0) -> DATA x8 (LSB first) -> STOP (txd=1) -> IDLE. Each state lasts exactly CLKS_PER_BIT cycles, counted by a 16-bit down-counter.
- RX: rxd passes through a 2-flop synchronizer. FSM IDLE -> START on falling edge of synchronized rxd; wait CLKS_PER_BIT/2 (truncating) cycles; if the line is high, treat as a glitch and return to IDLE. Otherwise sample 8 data bits at CLKS_PER_BIT intervals, then the stop bit.
- Stop bit high: byte pushed into RX storage. Stop bit low: byte discarded, frame_err set. FSM returns to IDLE in either case, ready for the next falling edge.
- Push while storage full: byte dropped, overrun set. A push and a pop in the same cycle while full: both accepted, no overrun.

## Timing
- Reset values: txd=1, rdata=16'h0000, TX and RX FSMs IDLE, storage empty, overrun=frame_err=0, tx_ready=1.
- Read latency: rdata valid on the cycle after the sel & re cycle, and held until the next read.
- TX: txd falls on the first rising edge after the accepted write. tx_ready drops in the same edge and returns high exactly 10*CLKS_PER_BIT cycles later.
- RX: rx_avail rises 2 cycles (synchronizer) after the stop-bit sample point, i.e. about 9.5*CLKS_PER_BIT+2 cycles after the start edge on rxd.
- rst asserted mid-frame aborts both FSMs on the same edge: txd returns high and the partial RX byte is discarded.

## Configuration
- UART_RX_FIFO_EN defined: RX storage is a RX_DEPTH-entry circular FIFO with wrapping read/write pointers and an occupancy count.
- UART_RX_FIFO_EN undefined: RX storage is a single holding register plus valid flag, and RX_DEPTH is ignored. Overrun behaves as for a FIFO of depth 1.

## Test plan
- Reset, CLKS_PER_BIT=4: rdata=0, txd=1, STATUS read returns 16'h0001.
- Write DATA 16'h1255 -> txd carries 0,1,0,1,0,1,0,1,0,1, each bit 4 cycles; STATUS bit0=0 during the frame and 1 after 40 cycles. A second write mid-frame is dropped.
- Drive 8N1 byte 8'hA3 on rxd -> STATUS=16'h0003; DATA read returns 16'h00A3; STATUS then returns 16'h0001.
- Send RX_DEPTH+1 bytes 8'h01..8'h05 without reading (FIFO build) -> STATUS bit2=1; reads return 01..04 and then 0. A second STATUS read shows bit2=0.
- Frame 8'h7E with stop bit low -> no byte stored, STATUS bit3=1. A 1-cycle low glitch on rxd -> no effect.
- Assert rst at cycle 10 of a TX frame -> txd=1 on the next edge and tx_ready=1.

Source files
------------

// File: rtl/uart_mmio.sv
// uart_mmio: memory-mapped 8N1 serial port for the 16-bit CPU I/O window.
//
// Optional feature macro: UART_RX_FIFO_EN
//   defined   -> receive storage is an RX_DEPTH-entry circular FIFO
//   undefined -> receive storage is a single holding register (depth 1)
//
// Parameters:
//   CLKS_PER_BIT  clock cycles per serial bit (4..65535)
//   RX_DEPTH      FIFO depth when UART_RX_FIFO_EN is defined (power of two, 2..16)
//
// Ports:
//   clk    system clock, rising edge
//   rst    synchronous active-high reset
//   sel    access targets this block this cycle
//   addr   0 = DATA register, 1 = STATUS register
//   we     write strobe (qualified by sel)
//   re     read strobe (qualified by sel)
//   wdata  write data, only [7:0] used
//   rdata  registered read data
//   txd    serial output, idle high
//   rxd    serial input, asynchronous to clk
//
// STATUS word: bit0 tx_ready, bit1 rx_avail, bit2 overrun (sticky),
//              bit3 frame_err (sticky), bits 15:4 zero.
module uart_mmio #(
  parameter int CLKS_PER_BIT = 434,
  parameter int RX_DEPTH     = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        sel,
  input  logic        addr,
  input  logic        we,
  input  logic        re,
  input  logic [15:0] wdata,
  output logic [15:0] rdata,
  output logic        txd,
  input  logic        rxd
);

  localparam logic [15:0] BIT_LAST  = 16'(CLKS_PER_BIT - 1);
  localparam logic [15:0] HALF_LAST = 16'(CLKS_PER_BIT / 2 - 1);

  typedef enum logic [1:0] {TX_IDLE, TX_START, TX_DATA, TX_STOP} tx_state_t;
  typedef enum logic [1:0] {RX_IDLE, RX_START, RX_DATA, RX_STOP} rx_state_t;

  tx_state_t   tx_state;
  logic [15:0] tx_cnt;
  logic [2:0]  tx_idx;
  logic [7:0]  tx_shift;

  rx_state_t   rx_state;
  logic [15:0] rx_cnt;
  logic [2:0]  rx_idx;
  logic [7:0]  rx_shift;
  logic        rxd_meta;
  logic        rxd_sync;
  logic        rxd_prev;
  logic        rx_push;
  logic        rx_ferr;
  logic [7:0]  rx_byte;

  logic        rx_avail;
  logic        rx_full;
  logic [7:0]  rx_head;
  logic        overrun;
  logic        frame_err;

  logic        tx_ready;
  logic        data_wr;
  logic        data_rd;
  logic        status_rd;
  logic        pop;
  logic        push_ok;
  logic        overrun_set;
  logic [15:0] status_word;

  logic        unused_ok;
  assign unused_ok = &{1'b0, wdata[15:8], RX_DEPTH[0]};

  assign tx_ready    = (tx_state == TX_IDLE);
  assign data_wr     = sel & we & ~addr;
  assign data_rd     = sel & re & ~addr;
  assign status_rd   = sel & re & addr;
  assign pop         = data_rd & rx_avail;
  // A full store still accepts a push when the same cycle pops the oldest byte.
  assign push_ok     = rx_push & (~rx_full | pop);
  assign overrun_set = rx_push & rx_full & ~pop;
  assign status_word = {12'h000, frame_err, overrun, rx_avail, tx_ready};

  // Transmitter: each state holds for CLKS_PER_BIT cycles; txd is registered
  // so it changes on the same edge as the state.
  always_ff @(posedge clk) begin
    if (rst) begin
      tx_state <= TX_IDLE;
      txd      <= 1'b1;
      tx_cnt   <= 16'd0;
      tx_idx   <= 3'd0;
      tx_shift <= 8'h00;
    end else begin
      case (tx_state)
        TX_IDLE: begin
          if (data_wr) begin
            tx_state <= TX_START;
            txd      <= 1'b0;
            tx_cnt   <= BIT_LAST;
            tx_shift <= wdata[7:0];
          end
        end
        TX_START: begin
          if (tx_cnt == 16'd0) begin
            tx_state <= TX_DATA;
            txd      <= tx_shift[0];
            tx_shift <= {1'b0, tx_shift[7:1]};
            tx_idx   <= 3'd0;
            tx_cnt   <= BIT_LAST;
          end else begin
            tx_cnt <= tx_cnt - 16'd1;
          end
        end
        TX_DATA: begin
          if (tx_cnt == 16'd0) begin
            tx_cnt <= BIT_LAST;
            if (tx_idx == 3'd7) begin
              tx_state <= TX_STOP;
              txd      <= 1'b1;
            end else begin
              txd      <= tx_shift[0];
              tx_shift <= {1'b0, tx_shift[7:1]};
              tx_idx   <= tx_idx + 3'd1;
            end
          end else begin
            tx_cnt <= tx_cnt - 16'd1;
          end
        end
        TX_STOP: begin
          if (tx_cnt == 16'd0) begin
            tx_state <= TX_IDLE;
          end else begin
            tx_cnt <= tx_cnt - 16'd1;
          end
        end
        default: begin
          tx_state <= TX_IDLE;
          txd      <= 1'b1;
        end
      endcase
    end
  end

  // Receiver: two-flop synchronizer, falling-edge start detect, half-bit
  // wait to reach the centre of the start bit, then full-bit steps.
  // Completed bytes and framing errors leave as one-cycle pulses.
  always_ff @(posedge clk) begin
    if (rst) begin
      rxd_meta <= 1'b1;
      rxd_sync <= 1'b1;
      rxd_prev <= 1'b1;
      rx_state <= RX_IDLE;
      rx_cnt   <= 16'd0;
      rx_idx   <= 3'd0;
      rx_shift <= 8'h00;
      rx_push  <= 1'b0;
      rx_ferr  <= 1'b0;
      rx_byte  <= 8'h00;
    end else begin
      rxd_meta <= rxd;
      rxd_sync <= rxd_meta;
      rxd_prev <= rxd_sync;
      rx_push  <= 1'b0;
      rx_ferr  <= 1'b0;
      case (rx_state)
        RX_IDLE: begin
          if (rxd_prev && !rxd_sync) begin
            rx_state <= RX_START;
            rx_cnt   <= HALF_LAST;
          end
        end
        RX_START: begin
          if (rx_cnt == 16'd0) begin
            if (rxd_sync) begin
              rx_state <= RX_IDLE;
            end else begin
              rx_state <= RX_DATA;
              rx_idx   <= 3'd0;
              rx_cnt   <= BIT_LAST;
            end
          end else begin
            rx_cnt <= rx_cnt - 16'd1;
          end
        end
        RX_DATA: begin
          if (rx_cnt == 16'd0) begin
            rx_shift <= {rxd_sync, rx_shift[7:1]};
            rx_cnt   <= BIT_LAST;
            if (rx_idx == 3'd7) begin
              rx_state <= RX_STOP;
            end else begin
              rx_idx <= rx_idx + 3'd1;
            end
          end else begin
            rx_cnt <= rx_cnt - 16'd1;
          end
        end
        RX_STOP: begin
          if (rx_cnt == 16'd0) begin
            rx_state <= RX_IDLE;
            if (rxd_sync) begin
              rx_push <= 1'b1;
              rx_byte <= rx_shift;
            end else begin
              rx_ferr <= 1'b1;
            end
          end else begin
            rx_cnt <= rx_cnt - 16'd1;
          end
        end
        default: rx_state <= RX_IDLE;
      endcase
    end
  end

`ifdef UART_RX_FIFO_EN
  localparam int PW = $clog2(RX_DEPTH);
  localparam int CW = PW + 1;

  logic [7:0]    fifo_mem [RX_DEPTH];
  logic [PW-1:0] wr_ptr;
  logic [PW-1:0] rd_ptr;
  logic [CW-1:0] count;

  assign rx_avail = (count != '0);
  assign rx_full  = (count == CW'(RX_DEPTH));
  assign rx_head  = fifo_mem[rd_ptr];

  // Circular FIFO; pointers wrap naturally because the depth is a power of two.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push_ok) begin
        fifo_mem[wr_ptr] <= rx_byte;
        wr_ptr           <= wr_ptr + PW'(1);
      end
      if (pop) begin
        rd_ptr <= rd_ptr + PW'(1);
      end
      case ({push_ok, pop})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
    end
  end
`else
  logic [7:0] hold_data;
  logic       hold_valid;

  assign rx_avail = hold_valid;
  assign rx_full  = hold_valid;
  assign rx_head  = hold_data;

  // Single holding register; a push in the same cycle as a pop refills it.
  always_ff @(posedge clk) begin
    if (rst) begin
      hold_data  <= 8'h00;
      hold_valid <= 1'b0;
    end else begin
      if (push_ok) begin
        hold_data  <= rx_byte;
        hold_valid <= 1'b1;
      end else if (pop) begin
        hold_valid <= 1'b0;
      end
    end
  end
`endif

  // Sticky error flags clear on a STATUS read unless a new error lands the
  // same cycle. rdata only changes on a read and is held otherwise.
  always_ff @(posedge clk) begin
    if (rst) begin
      overrun   <= 1'b0;
      frame_err <= 1'b0;
      rdata     <= 16'h0000;
    end else begin
      overrun   <= overrun_set | (overrun & ~status_rd);
      frame_err <= rx_ferr | (frame_err & ~status_rd);
      if (sel && re) begin
        if (addr) begin
          rdata <= status_word;
        end else if (rx_avail) begin
          rdata <= {8'h00, rx_head};
        end else begin
          rdata <= 16'h0000;
        end
      end
    end
  end

endmodule
